booth_seq_mul: RTL and testbench

Iterative radix-4 Booth multiplier controller: accepts one operand pair over a valid/ready handshake and sequences a single partial-product selector and one 2N-bit accumulator over N/2+1 Booth digits, one digit per cycle. It returns the 2N-bit product over a second valid/ready handshake. It is the area-optimised, multi-cycle counterpart of the team's combinational Booth array and uses the same digit encoding. It sits between an operand-issuing master and a result consumer, and supports both unsigned and two's-complement operation per transaction.

---
 rtl/booth_pkg.sv | 14 +
 rtl/booth_pp_sel.sv | 19 +
 rtl/booth_seq_mul.sv | 73 +++++++
 tb/tb_booth_seq_mul.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM states, radix-4 Booth digit codes, decode map and digit-count helper
package booth_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} digit_t;
  function automatic digit_t booth_decode(input logic [2:0] d);
    return (d == 3'd0 || d == 3'd7) ? ZERO :
           (d == 3'd1 || d == 3'd2) ? P1 :
           (d == 3'd3) ? P2 :
           (d == 3'd4) ? M2 : M1;
  endfunction
  function automatic int num_digits(input int n);
    return n / 2 + 1;
  endfunction
endpackage

// File: rtl/booth_pp_sel.sv
// booth_pp_sel: maps a 3-bit Booth digit and extended multiplicand a_ext to pp in {0, +-a_ext, +-2*a_ext} (W bits, two's complement)
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   digit,
  input  logic [W-1:0] a_ext,
  output logic [W-1:0] pp
);
  digit_t code;
  always_comb begin
    code = booth_decode(digit);
    pp = code == P1 ? a_ext :
         code == P2 ? a_ext << 1 :
         code == M1 ? -a_ext :
         code == M2 ? -(a_ext << 1) : '0;
  end
endmodule

// File: rtl/booth_seq_mul.sv
// booth_seq_mul: iterative radix-4 Booth multiplier; in_valid/in_ready/A/in2/sgn in, out_valid/out_ready/Mul out, busy while running
module booth_seq_mul
  import booth_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   in2,
  input  logic           sgn,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] Mul,
  output logic           busy
);
  localparam int D = num_digits(N);
  localparam int CW = $clog2(D);
  localparam int W = 2 * N;
  if (N < 2 || N % 2 != 0) begin : g_bad_n
    $error("booth_seq_mul: N must be even and >= 2");
  end
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, acc_q, acc_d, mul_q, mul_d, pp;
  logic [N+2:0] b_q, b_d;
  logic [CW-1:0] j_q, j_d;
  logic [2:0] digit;
  logic accept, last;
  booth_pp_sel #(.W(W)) u_pp_sel (.digit(digit), .a_ext(a_q), .pp(pp));
  assign Mul = mul_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    accept = in_valid && in_ready;
    last = j_q == CW'(N / 2);
    state_d = state_q == IDLE ? (accept ? RUN : IDLE) :
              state_q == RUN ? (last ? DONE : RUN) :
              (out_ready ? IDLE : DONE);
  end
  always_comb begin
    in_ready = state_q == IDLE;
    busy = state_q == RUN;
    out_valid = state_q == DONE;
  end
  // b_q[0] is the implicit B[-1]=0, so digit j sits at b_q[2j+2:2j]
  always_comb begin
    digit = 3'(b_q >> {j_q, 1'b0});
    a_d = accept ? {{N{sgn & A[N-1]}}, A} : a_q;
    b_d = accept ? {{2{sgn & in2[N-1]}}, in2, 1'b0} : b_q;
    acc_d = accept ? '0 : busy ? acc_q + (pp << {j_q, 1'b0}) : acc_q;
    j_d = accept ? '0 : busy ? j_q + CW'(1) : j_q;
    mul_d = busy && last ? acc_d : mul_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      j_q <= '0;
      mul_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      j_q <= j_d;
      mul_q <= mul_d;
    end
  end
endmodule

// File: tb/tb_booth_seq_mul.sv
// tb_booth_seq_mul: directed N=4 vectors and corner sequences plus an N=8 sweep against a reference product
module tb_booth_seq_mul;
  logic clk, rst;
  logic in_valid, in_ready, sgn, out_valid, out_ready, busy;
  logic [3:0] a4, b4;
  logic [7:0] mul;
  logic in_valid8, in_ready8, sgn8, out_valid8, out_ready8, busy8;
  logic [7:0] a8, b8;
  logic [15:0] mul8;
  int total = 0;
  int bad = 0;
  booth_seq_mul #(.N(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a4), .in2(b4),
    .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready), .Mul(mul), .busy(busy)
  );
  booth_seq_mul #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .A(a8), .in2(b8),
    .sgn(sgn8), .out_valid(out_valid8), .out_ready(out_ready8), .Mul(mul8), .busy(busy8)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[13];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic wait_ready4();
    int g;
    g = 0;
    while (!in_ready && g < 20) begin
      @(posedge clk); #1; g++;
    end
    if (!in_ready) chk("in_ready_wait", 0, 1);
  endtask
  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s, input logic early,
                      output logic [7:0] m, output int lat, output int bc);
    wait_ready4();
    in_valid = 1; a4 = a; b4 = b; sgn = s; out_ready = early;
    @(posedge clk); #1;
    in_valid = 0; a4 = ~a; b4 = ~b; sgn = ~s;
    lat = 0; bc = 0;
    while (!out_valid && lat < 20) begin
      bc += int'(busy);
      @(posedge clk); #1; lat++;
    end
    m = mul;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      output logic [15:0] m, output int lat);
    int g;
    g = 0;
    while (!in_ready8 && g < 20) begin
      @(posedge clk); #1; g++;
    end
    if (!in_ready8) chk("in_ready8_wait", 0, 1);
    in_valid8 = 1; a8 = a; b8 = b; sgn8 = s; out_ready8 = 0;
    @(posedge clk); #1;
    in_valid8 = 0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
      @(posedge clk); #1; lat++;
    end
    m = mul8;
    g = 0;
    while (g < 40) begin
      if (g > 0) chk("hold8", {out_valid8, mul8}, {1'b1, m});
      out_ready8 = 1'($urandom);
      @(posedge clk); #1;
      if (out_ready8) break;
      g++;
    end
    out_ready8 = 0;
  endtask
  initial begin
    logic [7:0] m;
    logic [15:0] m8, ae, be, e8;
    logic [7:0] ra, rb;
    logic [7:0] corner[4];
    int lat, bc;
    corner = '{8'h00, 8'hFF, 8'h80, 8'h7F};
    vecs[0]  = '{4'hF, 4'hF, 1'b0, 8'hE1};
    vecs[1]  = '{4'h8, 4'h8, 1'b1, 8'h40};
    vecs[2]  = '{4'h7, 4'h8, 1'b1, 8'hC8};
    vecs[3]  = '{4'h9, 4'h0, 1'b0, 8'h00};
    vecs[4]  = '{4'h0, 4'hD, 1'b0, 8'h00};
    vecs[5]  = '{4'hD, 4'hB, 1'b0, 8'h8F};
    vecs[6]  = '{4'hF, 4'hF, 1'b1, 8'h01};
    vecs[7]  = '{4'h7, 4'h7, 1'b1, 8'h31};
    vecs[8]  = '{4'hF, 4'h1, 1'b1, 8'hFF};
    vecs[9]  = '{4'h8, 4'h8, 1'b0, 8'h40};
    vecs[10] = '{4'h8, 4'h7, 1'b1, 8'hC8};
    vecs[11] = '{4'hF, 4'h8, 1'b0, 8'h78};
    vecs[12] = '{4'h8, 4'hF, 1'b1, 8'h08};
    rst = 1; in_valid = 0; a4 = 0; b4 = 0; sgn = 0; out_ready = 0;
    in_valid8 = 0; a8 = 0; b8 = 0; sgn8 = 0; out_ready8 = 0;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul", mul, 0);
    #10 rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 13; i++) begin
      run4(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, m, lat, bc);
      chk($sformatf("vec%0d_mul", i), m, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), lat, 3);
      chk($sformatf("vec%0d_busy", i), bc, 3);
    end
    wait_ready4();
    in_valid = 1; a4 = 4'hF; b4 = 4'hF; sgn = 0;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; a4 = 4'h3; b4 = 4'h2;
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_mul", mul, 8'hE1);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    run4(4'h5, 4'h3, 1'b0, 1'b1, m, lat, bc);
    chk("early_mul", m, 8'h0F);
    chk("early_lat", lat, 3);
    chk("early_out_valid_drop", out_valid, 0);
    chk("early_in_ready", in_ready, 1);
    wait_ready4();
    in_valid = 1; a4 = 4'hD; b4 = 4'hB; sgn = 0;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    chk("abort_busy_before", busy, 1);
    rst = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_mul", mul, 0);
    #2 rst = 0;
    @(posedge clk); #1;
    chk("abort_no_out_valid", out_valid, 0);
    run4(4'h6, 4'h7, 1'b0, 1'b0, m, lat, bc);
    chk("after_abort_mul", m, 8'd42);
    chk("after_abort_lat", lat, 3);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = i < 16 ? corner[i % 4] : 8'($urandom);
        rb = i < 16 ? corner[i / 4] : 8'($urandom);
        ae = s == 1 ? {{8{ra[7]}}, ra} : {8'h00, ra};
        be = s == 1 ? {{8{rb[7]}}, rb} : {8'h00, rb};
        e8 = ae * be;
        run8(ra, rb, 1'(s), m8, lat);
        chk($sformatf("n8_s%0d_%0h_%0h", s, ra, rb), m8, e8);
        chk("n8_lat", lat, 5);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
